// File: rtl/instr_memory_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the block-organised instruction memory: geometry
// constants, the read FSM state type and a helper that forms a byte address
// from a block address and a byte offset within that block.
// No ports (package).
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;
  localparam int BYTE_ADDR_W = 10;
  localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int BLK_ADDR_W  = BYTE_ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  // Byte k of block a lives at {a, k}; blocks are little-endian.
  function automatic logic [BYTE_ADDR_W-1:0] byte_addr(
    input logic [BLK_ADDR_W-1:0] blk,
    input logic [OFFSET_W-1:0]   off
  );
    return {blk, off};
  endfunction

endpackage

// File: rtl/instr_memory_if.sv
// -----------------------------------------------------------------------------
// instr_memory_if
// Bundles the cache-refill handshake and the byte-wide load port.
//   read      : block-read request, held until busywait falls
//   address   : block address, sampled when the request is accepted
//   readdata  : returned 128-bit block
//   busywait  : high while a read is pending or in flight
//   load_en   : byte write strobe
//   load_addr : byte address for the load port
//   load_data : byte to write
// Modports: master (cache / loader side), slave (memory side).
// -----------------------------------------------------------------------------
interface instr_memory_if;
  import imem_pkg::*;

  logic                   read;
  logic [BLK_ADDR_W-1:0]  address;
  logic [BLOCK_W-1:0]     readdata;
  logic                   busywait;
  logic                   load_en;
  logic [BYTE_ADDR_W-1:0] load_addr;
  logic [7:0]             load_data;

  modport master (
    output read, address, load_en, load_addr, load_data,
    input  readdata, busywait
  );

  modport slave (
    input  read, address, load_en, load_addr, load_data,
    output readdata, busywait
  );

endinterface

// File: rtl/instr_memory_array.sv
// -----------------------------------------------------------------------------
// imem_array
// 1024 x 8 storage with a synchronous byte write port and a combinational
// whole-block read. The array has no reset, so loaded program images
// survive a reset of the surrounding logic.
//   clock      : write clock
//   load_en    : byte write enable
//   load_addr  : byte write address
//   load_data  : byte write data
//   block_addr : block selected for the combinational read
//   block_data : 16 bytes of the selected block, byte k on [8k+7:8k]
// -----------------------------------------------------------------------------
module imem_array
  import imem_pkg::*;
(
  input  logic                   clock,
  input  logic                   load_en,
  input  logic [BYTE_ADDR_W-1:0] load_addr,
  input  logic [7:0]             load_data,
  input  logic [BLK_ADDR_W-1:0]  block_addr,
  output logic [BLOCK_W-1:0]     block_data
);

  logic [7:0] mem [0:(1<<BYTE_ADDR_W)-1];

  // Byte write port; active in every FSM state of the parent.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Gather the 16 bytes of the addressed block. Because the write above is
  // registered, a same-edge load is not visible here until after that edge.
  always_comb begin
    block_data = '0;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      block_data[8*k +: 8] = mem[byte_addr(block_addr, k[OFFSET_W-1:0])];
    end
  end

endmodule

// File: rtl/instr_memory.sv
// -----------------------------------------------------------------------------
// instr_memory
// Instruction memory behind the I-cache. A block read is accepted in IDLE,
// takes READ_CYCLES cycles in BUSY, registers the block into readdata on the
// completion edge and then spends one RELEASE cycle ignoring read, so a
// request still high after completion is not accepted twice.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : instr_memory_if slave (read/address/readdata/busywait + load port)
// Parameters:
//   READ_CYCLES  : busy cycles per block read after acceptance (>= 1)
//   BLOCK_ADDR_W : block address width
// -----------------------------------------------------------------------------
module instr_memory #(
  parameter int READ_CYCLES  = 4,
  parameter int BLOCK_ADDR_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  instr_memory_if.slave bus
);
  import imem_pkg::*;

  localparam int CNT_W = $clog2(READ_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_CYCLES - 1);

  state_t                  state;
  state_t                  next_state;
  logic [CNT_W-1:0]        count;
  logic [BLOCK_ADDR_W-1:0] latched_addr;
  logic [BLOCK_W-1:0]      readdata_q;
  logic [BLOCK_W-1:0]      block_data;
  logic                    busywait;
  logic                    accept;
  logic                    complete;

  imem_array u_array (
    .clock      (clock),
    .load_en    (bus.load_en),
    .load_addr  (bus.load_addr),
    .load_data  (bus.load_data),
    .block_addr (latched_addr),
    .block_data (block_data)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and Mealy outputs. busywait rises in the same cycle as read
  // so the cache never sees a low busywait while its request is pending.
  always_comb begin
    next_state = state;
    busywait   = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.read) begin
          busywait   = 1'b1;
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (count == '0) begin
          complete   = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Address latch, cycle counter and readdata register. The counter is
  // only reloaded on acceptance and stops at zero, so it never wraps.
  // readdata changes solely on the completion edge and takes the array
  // contents as they were before any load landing on that same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count        <= '0;
      latched_addr <= '0;
      readdata_q   <= '0;
    end else begin
      if (accept) begin
        latched_addr <= bus.address;
        count        <= CNT_LOAD;
      end else if (state == BUSY && count != '0) begin
        count <= count - 1'b1;
      end
      if (complete) begin
        readdata_q <= block_data;
      end
    end
  end

  assign bus.busywait = busywait;
  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_instr_memory.sv
// -----------------------------------------------------------------------------
// tb_instr_memory
// Scoreboard bench for instr_memory. The driver issues reads and pushes the
// expected block (taken from a byte-array model of the memory) together with
// the expected busywait run length onto a queue; a monitor sampling on the
// falling edge pops and compares whenever busywait falls.
// Inputs are driven 1 time unit after a rising edge, so a request is seen
// high for one falling edge in IDLE before acceptance, then READ_CYCLES
// falling edges in BUSY: the expected run is READ_CYCLES+1 samples.
// -----------------------------------------------------------------------------
module tb_instr_memory;

  localparam int READ_CYCLES = 4;

  typedef struct {
    logic [127:0] data;
    int           run;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  instr_memory_if bus ();

  instr_memory #(
    .READ_CYCLES  (READ_CYCLES),
    .BLOCK_ADDR_W (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] model_mem [0:1023];
  exp_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [127:0] model_block(input int blk);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[8*k +: 8] = model_mem[blk*16 + k];
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic load_byte(input int addr, input logic [7:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr[9:0];
    bus.load_data = data;
    @(posedge clock);
    #1;
    bus.load_en = 1'b0;
    model_mem[addr] = data;
  endtask

  // One block read. hold keeps read high after completion; new_addr >= 0
  // changes address two cycles into BUSY; col_addr >= 0 lands a load of
  // col_data on the completion edge (readdata must show the old byte).
  task automatic apply_stimulus(input int blk, input bit hold, input int new_addr,
                                input int col_addr, input logic [7:0] col_data);
    exp_t e;
    bit   done;
    e.data = model_block(blk);
    e.run  = READ_CYCLES + 1;
    exp_q.push_back(e);
    bus.read    = 1'b1;
    bus.address = blk[5:0];
    done = 1'b0;
    for (int i = 1; i <= 50 && !done; i++) begin
      @(posedge clock);
      #1;
      if (i == READ_CYCLES + 1 && col_addr >= 0) begin
        bus.load_en = 1'b0;
        model_mem[col_addr] = col_data;
      end
      if (!bus.busywait) begin
        done = 1'b1;
      end else begin
        if (i == 2 && new_addr >= 0) bus.address = new_addr[5:0];
        if (i == READ_CYCLES && col_addr >= 0) begin
          bus.load_en   = 1'b1;
          bus.load_addr = col_addr[9:0];
          bus.load_data = col_data;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      bus.load_en = 1'b0;
      $display("[TB] FAIL read_timeout block=%0d busywait never fell", blk);
    end
    if (!hold) bus.read = 1'b0;
    @(posedge clock);
    #1;
    if (hold) check_output("hold_reaccept_busywait", 128'(bus.busywait), 128'd1);
  endtask

  // Monitor: completion is a busywait fall outside reset.
  int   run_len   = 0;
  bit   prev_busy = 1'b0;
  exp_t mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.busywait) begin
        run_len++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_completion actual=%h required=none", bus.readdata);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("readdata", bus.readdata, mon_e.data);
          check_output("busy_len", 128'(run_len), 128'(mon_e.run));
        end
        run_len = 0;
      end
      prev_busy = bus.busywait;
    end
  end

  initial begin
    bus.read      = 1'b0;
    bus.address   = '0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;

    // Reset state: outputs cleared, busywait follows read in IDLE.
    repeat (2) @(posedge clock);
    #1;
    check_output("reset_readdata", bus.readdata, 128'h0);
    check_output("reset_busywait_low", 128'(bus.busywait), 128'd0);
    bus.read = 1'b1;
    #1;
    check_output("reset_busywait_follows_read", 128'(bus.busywait), 128'd1);
    bus.read = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Fill every byte so any block read has a defined expectation.
    for (int a = 0; a < 1024; a++) load_byte(a, 8'($urandom));

    // Block 0 holds 0x00..0x0F.
    for (int a = 0; a < 16; a++) load_byte(a, 8'(a));
    apply_stimulus(0, 1'b0, -1, -1, 8'h00);
    check_output("block0_literal", bus.readdata, 128'h0F0E0D0C0B0A09080706050403020100);

    // Top byte of block 63.
    load_byte(10'h3FF, 8'hA5);
    apply_stimulus(63, 1'b0, -1, -1, 8'h00);
    check_output("block63_top_byte", 128'(bus.readdata[127:120]), 128'hA5);

    // read held through completion: one RELEASE cycle, then re-accepted.
    apply_stimulus(7, 1'b1, -1, -1, 8'h00);
    apply_stimulus(7, 1'b0, -1, -1, 8'h00);

    // Address change during BUSY is ignored.
    apply_stimulus(5, 1'b0, 9, -1, 8'h00);

    // Reset mid-BUSY. read is dropped with reset, as the cache would do.
    bus.read    = 1'b1;
    bus.address = 6'd12;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    bus.read = 1'b0;
    #1;
    check_output("midbusy_reset_busywait", 128'(bus.busywait), 128'd0);
    check_output("midbusy_reset_readdata", bus.readdata, 128'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    apply_stimulus(12, 1'b0, -1, -1, 8'h00);

    // Load on the completion edge of a read of the same block.
    load_byte(10'h025, 8'h11);
    apply_stimulus(2, 1'b0, -1, 10'h025, 8'h77);
    check_output("collision_old_byte", 128'(bus.readdata[47:40]), 128'h11);
    apply_stimulus(2, 1'b0, -1, -1, 8'h00);
    check_output("collision_new_byte", 128'(bus.readdata[47:40]), 128'h77);

    // Randomized reads with interleaved loads and address wiggles.
    for (int n = 0; n < 24; n++) begin
      int nloads;
      nloads = int'($urandom_range(0, 3));
      for (int j = 0; j < nloads; j++) load_byte(int'($urandom_range(0, 1023)), 8'($urandom));
      apply_stimulus(int'($urandom_range(0, 63)), 1'b0,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : -1,
                     -1, 8'h00);
    end

    repeat (3) @(posedge clock);
    #1;
    check_output("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_memory.md
# instr_memory

Block-organised instruction memory that sits directly downstream of the instruction cache and serves 128-bit line refills over a busywait handshake. It holds 64 blocks of 16 bytes (1 KiB) and returns a whole block after a fixed, parameterised number of cycles. A byte-wide load port lets the testbench or boot logic write program images.

## Interface
- READ_CYCLES, 4: cycles busywait stays high per block read; must be ≥1.
- BLOCK_ADDR_W, 6: block-address width (64 blocks).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- read  in  1  block-read request from the cache; held until busywait falls.
- address  in  6  block address; sampled at acceptance.
- readdata  out  128  returned block; byte k of the block on [8k+7:8k].
- busywait  out  1  high while a read is in flight.
- load_en  in  1  byte write strobe for the load port.
- load_addr  in  10  byte address for the load port.
- load_data  in  8  byte to write.

## Operation
- Storage: 1024 bytes, little-endian within the block. Block `a`, byte k = mem[{a,4'b0}+k].
- FSM states:
  - IDLE: if read=1 at a posedge, latch address, load counter with READ_CYCLES-1, go to BUSY.
  - BUSY: decrement the counter each posedge. On the posedge where the counter is 0, register readdata from the latched block, then go to RELEASE.
  - RELEASE: ignore read for one cycle and return to IDLE unconditionally. This stops a read that is still high after completion from being re-accepted.
- busywait is combinational (Mealy): (state==IDLE && read) || state==BUSY.
  - It rises in the same cycle read rises, so the cache never samples a low busywait while its request is pending.
  - It is 0 in RELEASE.
- address changes during BUSY are ignored; the latched address is used.
- readdata holds its last value until the next completion. It is never updated outside the completion edge.
- Load port: while load_en=1, each posedge writes mem[load_addr] <= load_data, in any state.
  - If a load and a read completion hit the same block on the same edge, readdata takes the pre-write contents.
- The storage array is not cleared by reset; loaded contents survive reset.

## Timing
- Reset (asynchronous, reset=0):
  - state=IDLE, counter=0, readdata=128'h0.
  - busywait follows read combinationally while in IDLE (0 once read is low).
- Read accepted at posedge T0. readdata is valid and busywait is low after posedge T0+READ_CYCLES.
  - busywait is high from read rising until that edge: READ_CYCLES cycles after acceptance.
  - Example with READ_CYCLES=1: accept at T0, complete at T1.
- The earliest next acceptance is posedge T0+READ_CYCLES+2 (after one RELEASE cycle).
- Back-to-back misses therefore cost READ_CYCLES+2 cycles each.
- Reset asserted mid-BUSY: the read is aborted, busywait drops with reset, readdata=0, and nothing is written.
  - The cache must re-issue the read after reset.
- Counter width: $clog2(READ_CYCLES+1). The counter never wraps, because it is reloaded only in IDLE.

## Structure
- Shared package `imem_pkg`:
  - state enum {IDLE, BUSY, RELEASE};
  - BLOCK_BYTES=16, BLOCK_W=128, BYTE_ADDR_W=10.
- Sub-module `imem_array`: 1024×8 storage.
  - Byte write port (load).
  - Combinational 16-byte block read, selected by block address.
  - The top level contains only the FSM, the counter and the readdata register.

## Test plan
- Load bytes 0x00..0x0F at byte addresses 0x000..0x00F, read block 0 -> busywait high for exactly 4 cycles, then readdata=128'h0F0E…0100.
- Read block 63 after loading 0xA5 at byte address 0x3FF -> readdata[127:120]=8'hA5, other bytes as loaded.
- Hold read high through completion -> busywait is low for exactly the one RELEASE cycle, then a second read is accepted with busywait high again for 4 cycles.
- Change address from 5 to 9 two cycles into BUSY -> readdata returns block 5.
- Drive reset=0 mid-BUSY -> busywait drops immediately and readdata=0; after reset release, a re-issued read of the same block returns the loaded data (storage is intact).
- Load byte 0x77 into block 2 on the completion edge of a block-2 read -> readdata shows the old byte; the next read of block 2 shows 0x77.
